// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared states, HD44780 command constants and printable filter for the LCD line writer
package lcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    CHAR = 2'd2
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] LCD_LINE1_BASE    = 8'h00;
  localparam logic [7:0] LCD_LINE2_BASE    = 8'h40;
  localparam logic [7:0] LCD_BLANK         = 8'h20;
  localparam logic [7:0] LCD_PRINT_MIN     = 8'h20;
  localparam logic [7:0] LCD_PRINT_MAX     = 8'h7E;

  // Control codes would be interpreted by the controller, so they become blanks.
  function automatic logic [7:0] lcd_printable(input logic [7:0] c);
    return (c < LCD_PRINT_MIN || c > LCD_PRINT_MAX) ? LCD_BLANK : c;
  endfunction

endpackage

// File: rtl/lcd_frame_ram.sv
// rtl/lcd_frame_ram.sv - LINES*COLS x 8 frame buffer, one write port, asynchronous read, blank on reset
module lcd_frame_ram
  import lcd_pkg::*;
#(
  parameter int LINES = 2,
  parameter int COLS  = 16,
  parameter int DEPTH = LINES * COLS,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= LCD_BLANK;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/lcd_line_writer.sv
// rtl/lcd_line_writer.sv - frame buffer scanner feeding DDRAM address/data bytes to the LCD nibble driver
// Optional periodic rescan: define LCD_LINE_WRITER_AUTO_REFRESH_EN.
module lcd_line_writer
  import lcd_pkg::*;
#(
  parameter int LINES          = 2,
  parameter int COLS           = 16,
  parameter int REFRESH_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic       wr_line,
  input  logic [5:0] wr_col,
  input  logic [7:0] wr_data,
  input  logic       refresh,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_rs,
  output logic [7:0] cmd_data,
  output logic       busy
);

  localparam int         DEPTH     = LINES * COLS;
  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [5:0] COLS_W    = 6'(COLS);
  localparam logic [5:0] LAST_COL  = 6'(COLS - 1);
  localparam logic       LAST_LINE = 1'(LINES - 1);

  lcd_state_e state_q, state_d;
  logic       line_q, line_d;
  logic [5:0] col_q, col_d;
  logic       dirty_q, dirty_d;
  logic       valid_q, valid_d;
  logic       rs_q, rs_d;
  logic [7:0] data_q, data_d;
  logic       busy_q, busy_d;

  logic          wr_line_eff, wr_ok, auto_tick, xfer;
  logic [5:0]    rd_col;
  logic [AW-1:0] waddr, raddr;
  logic [7:0]    rdata;

  assign wr_line_eff = (LINES == 1) ? 1'b0 : wr_line;
  assign wr_ok       = wr_en && (wr_col < COLS_W);
  assign waddr       = AW'(wr_line_eff) * AW'(COLS) + AW'(wr_col);
  // Read the byte that will be presented after the pending transfer.
  assign rd_col      = (state_q == CHAR) ? 6'(col_q + 6'd1) : 6'd0;
  assign raddr       = AW'(line_q) * AW'(COLS) + AW'(rd_col);
  assign xfer        = valid_q && cmd_ready;

  lcd_frame_ram #(.LINES(LINES), .COLS(COLS), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .waddr (waddr),
    .wdata (lcd_printable(wr_data)),
    .raddr (raddr),
    .rdata (rdata)
  );

`ifdef LCD_LINE_WRITER_AUTO_REFRESH_EN
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;

  assign auto_tick = (ref_cnt_q == RW'(REFRESH_CYCLES - 1));
  assign ref_cnt_d = auto_tick ? '0 : ref_cnt_q + RW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ref_cnt_q <= '0;
    else        ref_cnt_q <= ref_cnt_d;
  end
`else
  // No periodic rescan; REFRESH_CYCLES is legal-range positive so this is constant 0.
  assign auto_tick = (REFRESH_CYCLES < 0);
`endif

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    col_d   = col_q;
    dirty_d = dirty_q;
    valid_d = valid_q;
    rs_d    = rs_q;
    data_d  = data_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (dirty_q || refresh) begin
          dirty_d = 1'b0;
          line_d  = 1'b0;
          col_d   = 6'd0;
          state_d = ADDR;
          busy_d  = 1'b1;
          valid_d = 1'b1;
          rs_d    = 1'b0;
          data_d  = LCD_CMD_SET_DDRAM | LCD_LINE1_BASE;
        end
      end
      ADDR: begin
        if (xfer) begin
          state_d = CHAR;
          col_d   = 6'd0;
          rs_d    = 1'b1;
          data_d  = rdata;
        end
      end
      CHAR: begin
        if (xfer) begin
          if (col_q < LAST_COL) begin
            col_d  = 6'(col_q + 6'd1);
            data_d = rdata;
          end else if (line_q < LAST_LINE) begin
            line_d  = 1'b1;
            col_d   = 6'd0;
            state_d = ADDR;
            rs_d    = 1'b0;
            data_d  = LCD_CMD_SET_DDRAM | LCD_LINE2_BASE;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A refresh during a scan is remembered, and any set beats the IDLE clear.
    if (state_q != IDLE && refresh) dirty_d = 1'b1;
    if (wr_en || auto_tick)         dirty_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      line_q  <= 1'b0;
      col_q   <= 6'd0;
      dirty_q <= 1'b1;
      valid_q <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      col_q   <= col_d;
      dirty_q <= dirty_d;
      valid_q <= valid_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_rs    = rs_q;
  assign cmd_data  = data_q;
  assign busy      = busy_q;

endmodule
